bp_train_queue: RTL and testbench

Branch-in-flight queue between fetch and the perceptron predictor's training port. At fetch it records each predicted branch (PC, prediction, perceptron sum, speculative GHR snapshot) and maintains the speculative global history the predictor indexes with. At execute it pops the oldest entry on branch resolution, detects mispredicts, repairs the speculative GHR, and emits a one-cycle training request when the perceptron rule requires it.

---
 rtl/bp_train_queue_pkg.sv | 18 +
 rtl/bp_train_queue_if.sv | 30 +++
 rtl/bp_train_queue.sv | 76 +++++++
 tb/tb_bp_train_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bp_train_queue_pkg.sv
// bp_pkg: shared widths, in-flight branch entry type and confidence helper
package bp_pkg;
  localparam int PC_W  = 12;
  localparam int H     = 12;
  localparam int SUM_W = 16;
  localparam int THETA = 37;
  typedef struct packed {
    logic [PC_W-1:0]         pc;
    logic                    pred;
    logic signed [SUM_W-1:0] sum;
    logic [H-1:0]            ghr;
  } bp_entry_t;
  function automatic logic bp_abs_gt(logic signed [SUM_W-1:0] sum, int theta);
    int a;
    a = int'(sum);
    return ((a < 0) ? -a : a) > theta;
  endfunction
endpackage

// File: rtl/bp_train_queue_if.sv
// bp_train_queue_if: fetch push, execute resolve and training bundle
interface bp_train_queue_if import bp_pkg::*; #(
  parameter int DEPTH = 4
);
  logic                         push_valid;
  logic                         push_ready;
  logic [PC_W-1:0]              push_pc;
  logic                         push_pred;
  logic signed [SUM_W-1:0]      push_sum;
  logic                         resolve_valid;
  logic                         resolve_taken;
  logic [PC_W-1:0]              resolve_pc;
  logic                         flush;
  logic [H-1:0]                 spec_ghr;
  logic                         train_valid;
  logic [PC_W-1:0]              train_pc;
  logic [H-1:0]                 train_ghr;
  logic                         train_taken;
  logic                         mispredict;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         err_sticky;
  modport master (
    output push_valid, push_pc, push_pred, push_sum, resolve_valid, resolve_taken, resolve_pc, flush,
    input  push_ready, spec_ghr, train_valid, train_pc, train_ghr, train_taken, mispredict, count, err_sticky
  );
  modport slave (
    input  push_valid, push_pc, push_pred, push_sum, resolve_valid, resolve_taken, resolve_pc, flush,
    output push_ready, spec_ghr, train_valid, train_pc, train_ghr, train_taken, mispredict, count, err_sticky
  );
endinterface

// File: rtl/bp_train_queue.sv
// bp_train_queue: in-flight branch queue feeding perceptron training and GHR repair
module bp_train_queue import bp_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int THR   = THETA
) (
  input logic              clk,
  input logic              rst,
  bp_train_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  bp_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [H-1:0]  r_spec_ghr, r_arch_ghr, r_train_ghr;
  logic [PC_W-1:0] r_train_pc;
  logic          r_train_valid, r_train_taken, r_mis, r_err;
  bp_entry_t     w_head;
  logic          w_push, w_res, w_mis, w_train, w_clear, w_wr;
  assign w_head  = r_mem[r_head];
  assign w_push  = bus.push_valid && bus.push_ready;
  assign w_res   = bus.resolve_valid && (r_count != '0);
  assign w_mis   = w_res && (w_head.pred != bus.resolve_taken);
  assign w_train = w_res && (w_mis || !bp_abs_gt(w_head.sum, THR));
  assign w_clear = bus.flush || w_mis;
  assign w_wr    = w_push && !w_clear;
  assign bus.push_ready  = r_count != CW'(DEPTH);
  assign bus.spec_ghr    = r_spec_ghr;
  assign bus.train_valid = r_train_valid;
  assign bus.train_pc    = r_train_pc;
  assign bus.train_ghr   = r_train_ghr;
  assign bus.train_taken = r_train_taken;
  assign bus.mispredict  = r_mis;
  assign bus.count       = r_count;
  assign bus.err_sticky  = r_err;
  // entry storage; validity is tracked by pointers and count alone
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_tail] <= '{pc: bus.push_pc, pred: bus.push_pred, sum: bus.push_sum, ghr: r_spec_ghr};
  // pointers, occupancy and speculative history with flush > mispredict > push/pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_spec_ghr <= '0;
    end else if (w_clear) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_spec_ghr <= bus.flush ? r_arch_ghr : {w_head.ghr[H-2:0], bus.resolve_taken};
    end else begin
      r_head     <= r_head + AW'(w_res);
      r_tail     <= r_tail + AW'(w_wr);
      r_count    <= r_count + CW'(w_wr) - CW'(w_res);
      r_spec_ghr <= w_wr ? {r_spec_ghr[H-2:0], bus.push_pred} : r_spec_ghr;
    end
  // committed history, one-cycle training pulse and sticky protocol error
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_arch_ghr    <= '0;
      r_train_valid <= 1'b0;
      r_train_pc    <= '0;
      r_train_ghr   <= '0;
      r_train_taken <= 1'b0;
      r_mis         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_arch_ghr    <= w_res ? {r_arch_ghr[H-2:0], bus.resolve_taken} : r_arch_ghr;
      r_train_valid <= w_train;
      r_train_pc    <= w_train ? w_head.pc : '0;
      r_train_ghr   <= w_train ? w_head.ghr : '0;
      r_train_taken <= w_train && bus.resolve_taken;
      r_mis         <= w_mis;
      r_err         <= r_err || (bus.resolve_valid && (!w_res || (bus.resolve_pc != w_head.pc)));
    end
endmodule

// File: tb/tb_bp_train_queue.sv
// tb_bp_train_queue: directed vectors with hand-computed expectations
module tb_bp_train_queue;
  import bp_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  bp_train_queue_if #(.DEPTH(4)) bus ();
  bp_train_queue #(.DEPTH(4), .THR(37)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bus.push_valid = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic set_push(input logic [11:0] pc, input logic pred, input logic [15:0] sum);
    bus.push_valid = 1'b1;
    bus.push_pc = pc;
    bus.push_pred = pred;
    bus.push_sum = sum;
  endtask
  task automatic set_res(input logic [11:0] pc, input logic taken);
    bus.resolve_valid = 1'b1;
    bus.resolve_pc = pc;
    bus.resolve_taken = taken;
  endtask
  task automatic push(input logic [11:0] pc, input logic pred, input logic [15:0] sum);
    set_push(pc, pred, sum);
    tick();
  endtask
  task automatic res(input logic [11:0] pc, input logic taken);
    set_res(pc, taken);
    tick();
  endtask
  initial begin
    bus.push_valid = 0; bus.push_pc = 0; bus.push_pred = 0; bus.push_sum = 0;
    bus.resolve_valid = 0; bus.resolve_taken = 0; bus.resolve_pc = 0; bus.flush = 0;
    #12;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_ready", 32'(bus.push_ready), 1);
    chk("rst_spec", 32'(bus.spec_ghr), 0);
    chk("rst_train", 32'(bus.train_valid), 0);
    chk("rst_mis", 32'(bus.mispredict), 0);
    chk("rst_err", 32'(bus.err_sticky), 0);
    rst = 1'b1;
    tick();
    push(12'h010, 1, 16'd50);
    chk("t1_count1", 32'(bus.count), 1);
    chk("t1_spec", 32'(bus.spec_ghr), 12'h001);
    res(12'h010, 1);
    chk("t1_notrain", 32'(bus.train_valid), 0);
    chk("t1_count0", 32'(bus.count), 0);
    bus.flush = 1'b1;
    tick();
    chk("t1_arch", 32'(bus.spec_ghr), 12'h001);
    push(12'h020, 1, 16'd10);
    chk("t2_spec", 32'(bus.spec_ghr), 12'h003);
    res(12'h020, 1);
    chk("t2_train", 32'(bus.train_valid), 1);
    chk("t2_mis", 32'(bus.mispredict), 0);
    chk("t2_pc", 32'(bus.train_pc), 12'h020);
    chk("t2_ghr", 32'(bus.train_ghr), 12'h001);
    chk("t2_taken", 32'(bus.train_taken), 1);
    tick();
    chk("t2_pulse", 32'(bus.train_valid), 0);
    push(12'h030, 1, 16'd100);
    push(12'h034, 0, -16'sd60);
    push(12'h038, 1, 16'd80);
    chk("t3_count3", 32'(bus.count), 3);
    chk("t3_spec", 32'(bus.spec_ghr), 12'h01D);
    set_res(12'h030, 0);
    set_push(12'h03C, 1, 16'd90);
    tick();
    chk("t3_mis", 32'(bus.mispredict), 1);
    chk("t3_train", 32'(bus.train_valid), 1);
    chk("t3_ghr", 32'(bus.train_ghr), 12'h003);
    chk("t3_taken", 32'(bus.train_taken), 0);
    chk("t3_count0", 32'(bus.count), 0);
    chk("t3_repair", 32'(bus.spec_ghr), 12'h006);
    tick();
    chk("t3_mis_pulse", 32'(bus.mispredict), 0);
    for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 1, 16'd100);
    chk("t4_full", 32'(bus.count), 4);
    chk("t4_ready0", 32'(bus.push_ready), 0);
    chk("t4_spec", 32'(bus.spec_ghr), 12'h06F);
    push(12'h104, 1, 16'd100);
    chk("t4_drop", 32'(bus.count), 4);
    chk("t4_spec_hold", 32'(bus.spec_ghr), 12'h06F);
    set_push(12'h104, 1, 16'd100);
    set_res(12'h100, 1);
    tick();
    chk("t4_popfull", 32'(bus.count), 3);
    chk("t4_conf", 32'(bus.train_valid), 0);
    set_push(12'h105, 1, 16'd100);
    set_res(12'h101, 1);
    tick();
    chk("t4_both", 32'(bus.count), 3);
    chk("t4_spec_wrap", 32'(bus.spec_ghr), 12'h0DF);
    res(12'h102, 1);
    res(12'h103, 1);
    chk("t4_count1", 32'(bus.count), 1);
    res(12'h105, 0);
    chk("t4_wrap_pc", 32'(bus.train_pc), 12'h105);
    chk("t4_wrap_ghr", 32'(bus.train_ghr), 12'h06F);
    chk("t4_wrap_mis", 32'(bus.mispredict), 1);
    chk("t4_repair", 32'(bus.spec_ghr), 12'h0DE);
    chk("t4_noerr", 32'(bus.err_sticky), 0);
    res(12'h0FF, 1);
    chk("t5_empty_err", 32'(bus.err_sticky), 1);
    chk("t5_empty_train", 32'(bus.train_valid), 0);
    chk("t5_empty_cnt", 32'(bus.count), 0);
    push(12'h060, 1, 16'd5);
    set_res(12'h060, 0);
    tick();
    push(12'h061, 1, 16'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_arst_cnt", 32'(bus.count), 0);
    chk("t6_arst_err", 32'(bus.err_sticky), 0);
    chk("t6_arst_spec", 32'(bus.spec_ghr), 0);
    chk("t6_arst_ready", 32'(bus.push_ready), 1);
    chk("t6_arst_train", 32'(bus.train_valid), 0);
    chk("t6_arst_mis", 32'(bus.mispredict), 0);
    rst = 1'b1;
    tick();
    push(12'h040, 1, 16'd5);
    res(12'h041, 1);
    chk("t7_pcmm_err", 32'(bus.err_sticky), 1);
    chk("t7_pcmm_pop", 32'(bus.count), 0);
    chk("t7_pcmm_train", 32'(bus.train_valid), 1);
    chk("t7_pcmm_pc", 32'(bus.train_pc), 12'h040);
    push(12'h050, 0, -16'sd100);
    push(12'h054, 0, -16'sd100);
    chk("t8_spec", 32'(bus.spec_ghr), 12'h004);
    chk("t8_count2", 32'(bus.count), 2);
    bus.flush = 1'b1;
    set_push(12'h058, 1, 16'd100);
    tick();
    chk("t8_flush_cnt", 32'(bus.count), 0);
    chk("t8_flush_spec", 32'(bus.spec_ghr), 12'h001);
    push(12'h070, 1, 16'h8000);
    res(12'h070, 1);
    chk("t9_mostneg", 32'(bus.train_valid), 0);
    push(12'h074, 1, 16'd37);
    res(12'h074, 1);
    chk("t9_eq_theta", 32'(bus.train_valid), 1);
    push(12'h078, 1, 16'd38);
    res(12'h078, 1);
    chk("t9_above", 32'(bus.train_valid), 0);
    push(12'h07C, 0, -16'sd37);
    res(12'h07C, 0);
    chk("t9_neg_eq", 32'(bus.train_valid), 1);
    chk("t9_neg_mis", 32'(bus.mispredict), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
